// File: rtl/simple_bus_pkg.sv
// Shared definitions for the simple processor's data-bus responder: register
// offsets from the top of the address space, qualifier states and access classes.
package simple_bus_pkg;

  localparam longint unsigned WCNT_OFS = 64'd4;
  localparam longint unsigned RCNT_OFS = 64'd3;
  localparam longint unsigned GPO_OFS  = 64'd2;
  localparam longint unsigned GPI_OFS  = 64'd1;

  typedef enum logic [1:0] {IDLE, ARMED, COMMIT} wq_state_t;

  typedef enum logic [1:0] {ACC_RAM, ACC_REG_RW, ACC_REG_RO, ACC_UNMAPPED} acc_class_t;

  // top is 2**addrsize; the four registers occupy the last four words.
  function automatic acc_class_t classify(input longint unsigned addr,
                                          input longint unsigned top,
                                          input longint unsigned ram_words);
    if (addr >= top - WCNT_OFS) begin
      if (addr == top - GPO_OFS) return ACC_REG_RW;
      return ACC_REG_RO;
    end
    if (addr < ram_words) return ACC_RAM;
    return ACC_UNMAPPED;
  endfunction

endpackage

// File: rtl/simple_mem_resp_wqual.sv
// Write qualifier: turns a store held on the strobe-less bus for two or more
// cycles into exactly one commit strobe; also exposes the previous bus sample.
module simple_mem_resp_wqual
  import simple_bus_pkg::*;
#(
  parameter int width    = 32,
  parameter int addrsize = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we_i,
  input  logic [addrsize-1:0] addr_i,
  input  logic [width-1:0]    data_i,
  output logic                commit_o,
  output logic                prev_we_o,
  output logic [addrsize-1:0] prev_addr_o
);

  wq_state_t           state_q, state_d;
  logic                we_q;
  logic [addrsize-1:0] addr_q;
  logic [width-1:0]    data_q;
  logic                same_t;

  // Only consulted while we_i is high, and we_q is always high in ARMED/COMMIT.
  assign same_t = (addr_i == addr_q) && (data_i == data_q);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    commit_o = 1'b0;
    // Written as if(!we) so an unknown we falls into the write branch.
    if (!we_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = ARMED;
        ARMED: begin
          if (same_t) begin
            state_d  = COMMIT;
            commit_o = 1'b1;
          end
        end
        COMMIT:  if (!same_t) state_d = ARMED;
        default: state_d = IDLE;
      endcase
    end
  end

  // prev we resets high so the first read after reset opens a new transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b1;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_i;
      addr_q  <= addr_i;
      data_q  <= data_i;
    end
  end

  assign prev_we_o   = we_q;
  assign prev_addr_o = addr_q;

endmodule

// File: rtl/simple_mem_resp.sv
// Memory-side bus responder: word RAM plus WCNT/RCNT/GPO/GPI registers at the top
// of the address space. Define BUS_ERR_EN to add the bus_err pulse output.
module simple_mem_resp
  import simple_bus_pkg::*;
#(
  parameter int width     = 32,
  parameter int addrsize  = 8,
  parameter int ram_words = 240
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [addrsize-1:0] address,
  input  logic [width-1:0]    dataout,
  output logic [width-1:0]    datain,
  output logic [width-1:0]    gpio_out,
  input  logic [width-1:0]    gpio_in
`ifdef BUS_ERR_EN
  ,
  output logic                bus_err
`endif
);

  localparam longint unsigned     TOP    = 64'd1 << addrsize;
  localparam logic [addrsize-1:0] A_WCNT = addrsize'(TOP - WCNT_OFS);
  localparam logic [addrsize-1:0] A_RCNT = addrsize'(TOP - RCNT_OFS);
  localparam int                  RAM_AW = (ram_words > 1) ? $clog2(ram_words) : 1;

  acc_class_t          cls;
  logic                commit, prev_we, rd_start;
  logic [addrsize-1:0] prev_addr;
  logic [RAM_AW-1:0]   ram_idx;
  logic [width-1:0]    mem [ram_words];
  logic [width-1:0]    datain_q, datain_d;
  logic [width-1:0]    wcnt_q, wcnt_d, rcnt_q, rcnt_d, gpo_q, gpo_d;

  assign cls     = classify(64'(address), TOP, 64'(ram_words));
  assign ram_idx = RAM_AW'(address);

  simple_mem_resp_wqual #(.width(width), .addrsize(addrsize)) u_wqual (
    .clk         (clk),
    .rst         (rst),
    .we_i        (we),
    .addr_i      (address),
    .data_i      (dataout),
    .commit_o    (commit),
    .prev_we_o   (prev_we),
    .prev_addr_o (prev_addr)
  );

  assign rd_start = !we && (prev_we || (address != prev_addr));

  // NOTE: the RAM array is deliberately not reset; its power-up contents are undefined.
  always_ff @(posedge clk) begin
    if (commit && (cls == ACC_RAM)) mem[ram_idx] <= dataout;
  end

  // Write-first: on a commit edge the read path returns the data being stored.
  always_comb begin
    datain_d = '0;
    case (cls)
      ACC_RAM:    datain_d = commit ? dataout : mem[ram_idx];
      ACC_REG_RW: datain_d = commit ? dataout : gpo_q;
      ACC_REG_RO: begin
        if (address == A_WCNT)      datain_d = wcnt_q;
        else if (address == A_RCNT) datain_d = rcnt_q;
        else                        datain_d = gpio_in;
      end
      default:    datain_d = '0;
    endcase
  end

  always_comb begin
    wcnt_d = wcnt_q;
    rcnt_d = rcnt_q;
    gpo_d  = gpo_q;
    if (commit && ((cls == ACC_RAM) || (cls == ACC_REG_RW))) wcnt_d = wcnt_q + width'(1);
    if (commit && (cls == ACC_REG_RW)) gpo_d = dataout;
    if (rd_start) rcnt_d = rcnt_q + width'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      datain_q <= '0;
      wcnt_q   <= '0;
      rcnt_q   <= '0;
      gpo_q    <= '0;
    end else begin
      datain_q <= datain_d;
      wcnt_q   <= wcnt_d;
      rcnt_q   <= rcnt_d;
      gpo_q    <= gpo_d;
    end
  end

  assign datain   = datain_q;
  assign gpio_out = gpo_q;

`ifdef BUS_ERR_EN
  logic bus_err_q, bus_err_d;

  assign bus_err_d = (commit && ((cls == ACC_REG_RO) || (cls == ACC_UNMAPPED)))
                  || (rd_start && (cls == ACC_UNMAPPED));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus_err_q <= 1'b0;
    else     bus_err_q <= bus_err_d;
  end

  assign bus_err = bus_err_q;
`endif

endmodule

// File: tb/tb_simple_mem_resp.sv
// Directed bench for simple_mem_resp: expected read data is queued as each cycle
// is driven and compared when the registered datain appears one cycle later.
module tb_simple_mem_resp;

  localparam int W  = 32;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic [AW-1:0] address;
  logic [W-1:0]  dataout, datain, gpio_out, gpio_in;
`ifdef BUS_ERR_EN
  logic          bus_err;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    string        tag;
    logic [W-1:0] val;
  } exp_t;

  exp_t sb[$];

  // Reference read-counter model, following the transaction-start rule.
  logic          m_prev_we   = 1'b1;
  logic [AW-1:0] m_prev_addr = '0;
  logic [W-1:0]  m_rcnt      = '0;

  always #5 clk = ~clk;

  simple_mem_resp #(.width(W), .addrsize(AW), .ram_words(240)) dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .address  (address),
    .dataout  (dataout),
    .datain   (datain),
    .gpio_out (gpio_out),
    .gpio_in  (gpio_in)
`ifdef BUS_ERR_EN
    ,
    .bus_err  (bus_err)
`endif
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_rd(input string tag, input logic [W-1:0] v);
    sb.push_back('{tag: tag, val: v});
  endtask

  // One clock: sample #1 after posedge, compare any queued expectation, return at negedge.
  task automatic tick();
    logic inc;
    exp_t e;
    inc = !rst && !we && (m_prev_we || (address != m_prev_addr));
    @(posedge clk);
    #1;
    if (rst) begin
      m_prev_we   = 1'b1;
      m_prev_addr = '0;
      m_rcnt      = '0;
    end else begin
      if (inc) m_rcnt = m_rcnt + 1;
      m_prev_we   = we;
      m_prev_addr = address;
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, datain, e.val);
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic w, input logic [AW-1:0] a, input logic [W-1:0] d);
    we      = w;
    address = a;
    dataout = d;
  endtask

  task automatic store(input logic [AW-1:0] a, input logic [W-1:0] d, input logic chk);
    drive(1'b1, a, d);
    tick();
    if (chk) expect_rd("write_first", d);
    tick();
  endtask

  task automatic rd(input string tag, input logic [AW-1:0] a, input logic [W-1:0] exp);
    drive(1'b0, a, dataout);
    expect_rd(tag, exp);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 8'h00, 32'h0);
    gpio_in = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_datain", datain, 32'h0);
    check("rst_gpio_out", gpio_out, 32'h0);
`ifdef BUS_ERR_EN
    check("rst_bus_err", {31'b0, bus_err}, 32'h0);
`endif
    rst = 1'b0;

    rd("wcnt_reset", 8'hFC, 32'h0);
    rd("rcnt_first", 8'hFD, m_rcnt);

    // Store held 2 cycles commits once; 10 more held cycles change nothing.
    store(8'h05, 32'hDEAD_BEEF, 1'b1);
    repeat (10) tick();
    rd("ram5", 8'h05, 32'hDEAD_BEEF);
    rd("rcnt_after_read", 8'hFD, m_rcnt);
    rd("rcnt_held_read", 8'hFD, m_rcnt);
    rd("rcnt_held_read2", 8'hFD, m_rcnt);
    rd("wcnt_once", 8'hFC, 32'd1);

    // One-cycle write glitch never commits.
    store(8'h07, 32'h1111_1111, 1'b1);
    drive(1'b1, 8'h07, 32'h2222_2222);
    tick();
    rd("glitch_ram7", 8'h07, 32'h1111_1111);
    rd("glitch_wcnt", 8'hFC, 32'd2);

    // GPIO registers.
    store(8'hFE, 32'h0000_00A5, 1'b1);
    check("gpio_out_write", gpio_out, 32'h0000_00A5);
    gpio_in = 32'h0000_003C;
    rd("gpi_read", 8'hFF, 32'h0000_003C);
    rd("gpo_read", 8'hFE, 32'h0000_00A5);

    // RAM edge and first unmapped word.
    store(8'hEF, 32'h0EF0_0EF0, 1'b1);
    rd("ram_last", 8'hEF, 32'h0EF0_0EF0);
`ifdef BUS_ERR_EN
    check("bus_err_ram_rd", {31'b0, bus_err}, 32'h0);
`endif
    rd("unmapped_f0", 8'hF0, 32'h0);
`ifdef BUS_ERR_EN
    check("bus_err_rd_f0", {31'b0, bus_err}, 32'h1);
`endif

    // Writes to a read-only register and an unmapped word are dropped.
    store(8'hFC, 32'h0000_1234, 1'b0);
`ifdef BUS_ERR_EN
    check("bus_err_wr_wcnt", {31'b0, bus_err}, 32'h1);
    tick();
    check("bus_err_one_pulse", {31'b0, bus_err}, 32'h0);
`else
    tick();
`endif
    store(8'hF5, 32'h0000_5555, 1'b0);
`ifdef BUS_ERR_EN
    check("bus_err_wr_f5", {31'b0, bus_err}, 32'h1);
`endif
    rd("ro_wcnt", 8'hFC, 32'd4);
`ifdef BUS_ERR_EN
    check("bus_err_ro_rd", {31'b0, bus_err}, 32'h0);
`endif
    rd("unmapped_f5", 8'hF5, 32'h0);
`ifdef BUS_ERR_EN
    check("bus_err_rd_f5", {31'b0, bus_err}, 32'h1);
`endif
    check("gpio_keep", gpio_out, 32'h0000_00A5);

    // Reset while ARMED on a new store to 0x10: no commit, registers cleared.
    store(8'h10, 32'hCAFE_0001, 1'b1);
    drive(1'b1, 8'h10, 32'hBADB_AD00);
    tick();
    rst = 1'b1;
    tick();
    check("rst_mid_datain", datain, 32'h0);
    check("rst_mid_gpio", gpio_out, 32'h0);
    drive(1'b0, 8'h10, 32'hBADB_AD00);
    rst = 1'b0;
    rd("ram10_kept", 8'h10, 32'hCAFE_0001);
    rd("wcnt_after_rst", 8'hFC, 32'h0);
    rd("rcnt_after_rst", 8'hFD, m_rcnt);

    // Counter wrap from a backdoor preset.
    force dut.wcnt_q = 32'hFFFF_FFFE;
    tick();
    release dut.wcnt_q;
    store(8'h20, 32'h0000_0001, 1'b1);
    rd("wcnt_max", 8'hFC, 32'hFFFF_FFFF);
    store(8'h21, 32'h0000_0002, 1'b1);
    rd("wcnt_wrap", 8'hFC, 32'h0);
    rd("ram20", 8'h20, 32'h0000_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
